// File: rtl/ham_decode_pipe.sv
// rtl/ham_decode_pipe.sv - two-stage Hamming(7,4) pair decoder with valid/ready handshake
// and saturating word/error statistics counters.
module ham_decode_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      ham_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pcm_code,
  output logic [2:0]       syn_lo,
  output logic [2:0]       syn_hi,
  output logic             err_lo,
  output logic             err_hi,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[2] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[3] ^ c[5] ^ c[6],
            c[0] ^ c[3] ^ c[4] ^ c[6]};
  endfunction

  // Syndrome value is not the bit index: parity bits sit at the power-of-two codes.
  function automatic logic [3:0] correct(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] flip;
    case (s)
      3'b001:  flip = 7'b000_0001;
      3'b010:  flip = 7'b000_0010;
      3'b100:  flip = 7'b000_0100;
      3'b011:  flip = 7'b000_1000;
      3'b101:  flip = 7'b001_0000;
      3'b110:  flip = 7'b010_0000;
      3'b111:  flip = 7'b100_0000;
      default: flip = 7'b000_0000;
    endcase
    return (c ^ flip) >> 3;
  endfunction

  logic        s1_valid;
  logic [13:0] s1_code;
  logic [2:0]  s1_syn_lo;
  logic [2:0]  s1_syn_hi;
  logic        s2_load;
  logic        s1_load;
  logic        nxt_err_lo;
  logic        nxt_err_hi;
  logic [1:0]  err_inc;
  logic [CNT_W:0] err_sum;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  assign nxt_err_lo = |s1_syn_lo;
  assign nxt_err_hi = |s1_syn_hi;
  assign err_inc    = {1'b0, nxt_err_lo} + {1'b0, nxt_err_hi};
  assign err_sum    = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, err_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_syn_lo <= '0;
      s1_syn_hi <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_code   <= ham_code;
        s1_syn_lo <= syndrome(ham_code[6:0]);
        s1_syn_hi <= syndrome(ham_code[13:7]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pcm_code  <= '0;
      syn_lo    <= '0;
      syn_hi    <= '0;
      err_lo    <= 1'b0;
      err_hi    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      pcm_code  <= {correct(s1_code[13:7], s1_syn_hi), correct(s1_code[6:0], s1_syn_lo)};
      syn_lo    <= s1_syn_lo;
      syn_hi    <= s1_syn_hi;
      err_lo    <= nxt_err_lo;
      err_hi    <= nxt_err_hi;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (cnt_clr) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (s2_load) begin
      if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_ham_decode_pipe.sv
// tb/tb_ham_decode_pipe.sv - directed bench for ham_decode_pipe; a 4-bit-counter
// instance shares the stimulus for the saturation checks.
module tb_ham_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [13:0] ham_code;
  logic        out_ready;
  logic        cnt_clr;

  logic        a_in_ready, a_out_valid, a_err_lo, a_err_hi;
  logic [7:0]  a_pcm_code;
  logic [2:0]  a_syn_lo, a_syn_hi;
  logic [15:0] a_word_cnt, a_err_cnt;

  logic        b_in_ready, b_out_valid, b_err_lo, b_err_hi;
  logic [7:0]  b_pcm_code;
  logic [2:0]  b_syn_lo, b_syn_hi;
  logic [3:0]  b_word_cnt, b_err_cnt;

  int tests = 0;
  int fails = 0;

  ham_decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .ham_code(ham_code),
    .out_valid(a_out_valid), .out_ready(out_ready), .pcm_code(a_pcm_code),
    .syn_lo(a_syn_lo), .syn_hi(a_syn_hi), .err_lo(a_err_lo), .err_hi(a_err_hi),
    .cnt_clr(cnt_clr), .word_cnt(a_word_cnt), .err_cnt(a_err_cnt)
  );

  ham_decode_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .ham_code(ham_code),
    .out_valid(b_out_valid), .out_ready(out_ready), .pcm_code(b_pcm_code),
    .syn_lo(b_syn_lo), .syn_hi(b_syn_hi), .err_lo(b_err_lo), .err_hi(b_err_hi),
    .cnt_clr(cnt_clr), .word_cnt(b_word_cnt), .err_cnt(b_err_cnt)
  );

  always #5 clk = ~clk;

  // code, pcm, syn_lo, syn_hi, err_lo, err_hi
  logic [13:0] v_code [10] = '{14'h292D, 14'h2925, 14'h092D, 14'h3FFF, 14'h0000,
                               14'h3FFE, 14'h292E, 14'h0925, 14'h29AD, 14'h2B2D};
  logic [7:0]  v_pcm  [10] = '{8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h00,
                               8'hFF, 8'hA4, 8'hA5, 8'hA5, 8'hA5};
  logic [2:0]  v_slo  [10] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd3, 3'd0, 3'd0};
  logic [2:0]  v_shi  [10] = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd1, 3'd4};
  logic        v_elo  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        v_ehi  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [13:0] bb_code [4] = '{14'h292D, 14'h3FFF, 14'h0000, 14'h309E};
  logic [7:0]  bb_pcm  [4] = '{8'hA5, 8'hFF, 8'h00, 8'hC3};

  task automatic drive_word(input logic [13:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    ham_code = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi});
    end
    tests++;
    if (a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
    end
    tests++;
    if ({a_word_cnt, a_err_cnt, b_word_cnt, b_err_cnt} !== 40'd0) begin
      fails++;
      $display("FAIL reset_counters: got %h %h expected 0 0", a_word_cnt, a_err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    int exp_w = 0;
    int exp_e = 0;
    for (int i = 0; i < 10; i++) begin
      drive_word(v_code[i]);
      tests++;
      if (a_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL decode_early_%0d: out_valid got %b expected 0", i, a_out_valid);
      end
      @(negedge clk);
      exp_w++;
      exp_e += int'(v_elo[i]) + int'(v_ehi[i]);
      tests++;
      if ({a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi} !==
          {1'b1, v_pcm[i], v_slo[i], v_shi[i], v_elo[i], v_ehi[i]}) begin
        fails++;
        $display("FAIL decode_%0d code %h: got v%b pcm %h syn %0d/%0d err %b%b expected v1 pcm %h syn %0d/%0d err %b%b",
                 i, v_code[i], a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi,
                 v_pcm[i], v_slo[i], v_shi[i], v_elo[i], v_ehi[i]);
      end
      tests++;
      if (a_word_cnt !== 16'(exp_w) || a_err_cnt !== 16'(exp_e)) begin
        fails++;
        $display("FAIL decode_cnt_%0d: got words %0d errs %0d expected %0d %0d", i, a_word_cnt, a_err_cnt, exp_w, exp_e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    bit saw_block = 1'b0;
    logic [16:0] held = '0;
    pulse_clr();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 4);
      ham_code  = (sent < 4) ? bb_code[sent] : 14'h0;
      #1;
      if (cyc == 2) held = {a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi};
      if (cyc == 3 || cyc == 4) begin
        tests++;
        if ({a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi} !== held || held[16] !== 1'b1) begin
          fails++;
          $display("FAIL bb_hold_cyc%0d: got %h expected %h (valid)", cyc, {a_out_valid, a_pcm_code, a_syn_lo, a_syn_hi, a_err_lo, a_err_hi}, held);
        end
      end
      if (in_valid && !out_ready && !a_in_ready) saw_block = 1'b1;
      if (a_out_valid && out_ready) begin
        tests++;
        if (a_pcm_code !== bb_pcm[got]) begin
          fails++;
          $display("FAIL bb_order_%0d: got %h expected %h", got, a_pcm_code, bb_pcm[got]);
        end
        got++;
      end
      if (in_valid && a_in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (got != 4) begin
      fails++;
      $display("FAIL bb_count: got %0d outputs expected 4", got);
    end
    tests++;
    if (!saw_block) begin
      fails++;
      $display("FAIL bb_in_ready: got never low expected low while stalled");
    end
    tests++;
    if (a_word_cnt !== 16'd4) begin
      fails++;
      $display("FAIL bb_word_cnt: got %0d expected 4", a_word_cnt);
    end
    @(negedge clk);
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bb_drain: out_valid got %b expected 0", a_out_valid);
    end
  endtask

  task automatic test_saturation();
    pulse_clr();
    for (int i = 0; i < 7; i++) drive_word(14'h0925);
    @(negedge clk);
    tests++;
    if (b_err_cnt !== 4'hE || b_word_cnt !== 4'd7) begin
      fails++;
      $display("FAIL sat_pre: got errs %h words %h expected e 7", b_err_cnt, b_word_cnt);
    end
    drive_word(14'h0925);
    @(negedge clk);
    tests++;
    if (b_err_cnt !== 4'hF) begin
      fails++;
      $display("FAIL sat_stop: got %h expected f", b_err_cnt);
    end
    drive_word(14'h0925);
    @(negedge clk);
    tests++;
    if (b_err_cnt !== 4'hF || b_word_cnt !== 4'd9) begin
      fails++;
      $display("FAIL sat_hold: got errs %h words %h expected f 9", b_err_cnt, b_word_cnt);
    end
    drive_word(14'h0925);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    tests++;
    if ({b_err_cnt, b_word_cnt} !== 8'h00 || {a_err_cnt, a_word_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL clr_wins: got small %h/%h wide %h/%h expected 0", b_err_cnt, b_word_cnt, a_err_cnt, a_word_cnt);
    end
    tests++;
    if ({a_out_valid, a_err_lo, a_err_hi, a_pcm_code} !== {3'b111, 8'hA5}) begin
      fails++;
      $display("FAIL clr_pipe: got v%b err %b%b pcm %h expected v1 err 11 pcm a5", a_out_valid, a_err_lo, a_err_hi, a_pcm_code);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    in_valid = 1'b1;
    ham_code = 14'h3FFF;
    @(negedge clk);
    ham_code = 14'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({a_out_valid, a_pcm_code, a_in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid_out: got v%b pcm %h rdy %b expected v0 pcm 00 rdy 1", a_out_valid, a_pcm_code, a_in_ready);
    end
    tests++;
    if ({a_word_cnt, a_err_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_cnt: got %h %h expected 0 0", a_word_cnt, a_err_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_stale: out_valid got %b expected 0", a_out_valid);
    end
    drive_word(14'h292D);
    tests++;
    if (a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_after_early: out_valid got %b expected 0", a_out_valid);
    end
    @(negedge clk);
    tests++;
    if ({a_out_valid, a_pcm_code, a_word_cnt} !== {1'b1, 8'hA5, 16'd1}) begin
      fails++;
      $display("FAIL rst_after: got v%b pcm %h words %0d expected v1 pcm a5 words 1", a_out_valid, a_pcm_code, a_word_cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    ham_code  = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
